// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_operand_stage_if : ID/EX stage bus (decode, writeback taps, ALU outputs)
// Revision 1.0
// ---------------------------------------------------------------------------
interface ex_operand_stage_if #(
  parameter int WIDTH   = 8,
  parameter int RADDR_W = 5
);
  logic               id_valid;
  logic [WIDTH-1:0]   id_rs_data;
  logic [WIDTH-1:0]   id_rt_data;
  logic [WIDTH-1:0]   id_imm;
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;
  logic [RADDR_W-1:0] id_rd;
  logic               id_alusrc;
  logic               id_regdst;
  logic               id_regwrite;
  logic               id_memread;
  logic               id_memwrite;
  logic [1:0]         id_aluop;
  logic [5:0]         id_funct;
  logic               stall;
  logic               flush;
  logic               mem_regwrite;
  logic [RADDR_W-1:0] mem_rd;
  logic [WIDTH-1:0]   mem_result;
  logic               wb_regwrite;
  logic [RADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]   wb_result;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [2:0]         alu_op;
  logic               ex_valid;
  logic               ex_regwrite;
  logic               ex_memread;
  logic               ex_memwrite;
  logic [RADDR_W-1:0] ex_dest;
  logic [WIDTH-1:0]   ex_store_data;
  logic               load_use_stall;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite,
           id_aluop, id_funct, stall, flush,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    input  alu_a, alu_b, alu_op, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_dest, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite,
           id_aluop, id_funct, stall, flush,
           mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
    output alu_a, alu_b, alu_op, ex_valid, ex_regwrite, ex_memread,
           ex_memwrite, ex_dest, ex_store_data, load_use_stall
  );
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_operand_stage : ID/EX register, ALU op decode, operand forwarding, load-use
// Revision 1.0
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int WIDTH   = 8,
  parameter int RADDR_W = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  ex_operand_stage_if.slave  ex_bus
);

  localparam logic [2:0] c_op_and  = 3'd0;
  localparam logic [2:0] c_op_or   = 3'd1;
  localparam logic [2:0] c_op_add  = 3'd2;
  localparam logic [2:0] c_op_zero = 3'd3;
  localparam logic [2:0] c_op_sub  = 3'd6;
  localparam logic [2:0] c_op_slt  = 3'd7;

  localparam logic [RADDR_W-1:0] c_reg_zero = '0;

  logic               valid_q,    valid_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q,  memread_d;
  logic               memwrite_q, memwrite_d;
  logic               alusrc_q,   alusrc_d;
  logic [WIDTH-1:0]   rs_data_q,  rs_data_d;
  logic [WIDTH-1:0]   rt_data_q,  rt_data_d;
  logic [WIDTH-1:0]   imm_q,      imm_d;
  logic [RADDR_W-1:0] rs_q,       rs_d;
  logic [RADDR_W-1:0] rt_q,       rt_d;
  logic [RADDR_W-1:0] dest_q,     dest_d;
  logic [2:0]         alu_op_q,   alu_op_d;

  logic [2:0]         w_op_dec;
  logic [WIDTH-1:0]   w_fwd_rs;
  logic [WIDTH-1:0]   w_fwd_rt;

  always_comb begin
    w_op_dec = c_op_zero;
    case (ex_bus.id_aluop)
      2'b00: w_op_dec = c_op_add;
      2'b01: w_op_dec = c_op_sub;
      2'b11: w_op_dec = c_op_or;
      default: begin
        case (ex_bus.id_funct)
          6'b100000: w_op_dec = c_op_add;
          6'b100010: w_op_dec = c_op_sub;
          6'b100100: w_op_dec = c_op_and;
          6'b100101: w_op_dec = c_op_or;
          6'b101010: w_op_dec = c_op_slt;
          default:   w_op_dec = c_op_zero;
        endcase
      end
    endcase
  end

  // Flush beats stall; stall holds; otherwise capture with controls gated by id_valid.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dest_d     = dest_q;
    alu_op_d   = alu_op_q;
    if (ex_bus.flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      dest_d     = '0;
      alu_op_d   = 3'd0;
    end else if (!ex_bus.stall) begin
      valid_d    = ex_bus.id_valid;
      regwrite_d = ex_bus.id_regwrite & ex_bus.id_valid;
      memread_d  = ex_bus.id_memread  & ex_bus.id_valid;
      memwrite_d = ex_bus.id_memwrite & ex_bus.id_valid;
      alusrc_d   = ex_bus.id_alusrc;
      rs_data_d  = ex_bus.id_rs_data;
      rt_data_d  = ex_bus.id_rt_data;
      imm_d      = ex_bus.id_imm;
      rs_d       = ex_bus.id_rs;
      rt_d       = ex_bus.id_rt;
      dest_d     = ex_bus.id_regdst ? ex_bus.id_rd : ex_bus.id_rt;
      alu_op_d   = w_op_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      alu_op_q   <= 3'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      alu_op_q   <= alu_op_d;
    end
  end

  // Youngest producer (EX/MEM) wins; r0 is hard-wired and never forwarded.
  always_comb begin
    w_fwd_rs = rs_data_q;
    if (ex_bus.mem_regwrite && (ex_bus.mem_rd != c_reg_zero) && (ex_bus.mem_rd == rs_q))
      w_fwd_rs = ex_bus.mem_result;
    else if (ex_bus.wb_regwrite && (ex_bus.wb_rd != c_reg_zero) && (ex_bus.wb_rd == rs_q))
      w_fwd_rs = ex_bus.wb_result;
  end

  always_comb begin
    w_fwd_rt = rt_data_q;
    if (ex_bus.mem_regwrite && (ex_bus.mem_rd != c_reg_zero) && (ex_bus.mem_rd == rt_q))
      w_fwd_rt = ex_bus.mem_result;
    else if (ex_bus.wb_regwrite && (ex_bus.wb_rd != c_reg_zero) && (ex_bus.wb_rd == rt_q))
      w_fwd_rt = ex_bus.wb_result;
  end

  assign ex_bus.alu_a         = w_fwd_rs;
  assign ex_bus.alu_b         = alusrc_q ? imm_q : w_fwd_rt;
  assign ex_bus.ex_store_data = w_fwd_rt;
  assign ex_bus.alu_op        = alu_op_q;
  assign ex_bus.ex_valid      = valid_q;
  assign ex_bus.ex_regwrite   = regwrite_q;
  assign ex_bus.ex_memread    = memread_q;
  assign ex_bus.ex_memwrite   = memwrite_q;
  assign ex_bus.ex_dest       = dest_q;

  assign ex_bus.load_use_stall = ex_bus.id_valid & valid_q & memread_q
                               & (dest_q != c_reg_zero)
                               & ((dest_q == ex_bus.id_rs) | (dest_q == ex_bus.id_rt));

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ex_operand_stage : directed self-checking bench for ex_operand_stage
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_operand_stage_if #(.WIDTH(8), .RADDR_W(5)) bus ();

  ex_operand_stage #(.WIDTH(8), .RADDR_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .ex_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_alusrc = 0; bus.id_regdst = 0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.id_aluop = 2'b00; bus.id_funct = 6'd0; bus.stall = 0; bus.flush = 0;
    bus.mem_regwrite = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  task automatic issue_add();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct = 6'b100000;
    bus.id_rs = 5'd1; bus.id_rs_data = 8'd5; bus.id_rt = 5'd2; bus.id_rt_data = 8'd3;
    bus.id_rd = 5'd3; bus.id_regdst = 1; bus.id_regwrite = 1; bus.id_alusrc = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.id_imm = 8'h00;
  endtask

  logic [1:0] sw_aluop [9];
  logic [5:0] sw_funct [9];
  logic [2:0] sw_exp   [9];

  initial begin
    checks = 0;
    errors = 0;
    sw_aluop = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    sw_funct = '{6'h00, 6'h00, 6'h00, 6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h00};
    sw_exp   = '{3'd2,  3'd6,  3'd1,  3'd0,  3'd1,  3'd2,  3'd6,  3'd7,  3'd3};

    clear_inputs();
    reset = 1;
    tick();
    tick();
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_ex_dest", bus.ex_dest, 0);
    check("rst_lus", bus.load_use_stall, 0);
    reset = 0;

    // Basic R-type add
    issue_add();
    tick();
    check("add_alu_op", bus.alu_op, 2);
    check("add_alu_a", bus.alu_a, 5);
    check("add_alu_b", bus.alu_b, 3);
    check("add_ex_valid", bus.ex_valid, 1);
    check("add_ex_dest", bus.ex_dest, 3);
    check("add_ex_regwrite", bus.ex_regwrite, 1);
    check("add_store", bus.ex_store_data, 3);

    // Forwarding priority
    clear_inputs();
    bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_rs_data = 8'd1;
    bus.id_rt = 5'd5; bus.id_rt_data = 8'd9;
    tick();
    bus.id_valid = 0;
    bus.mem_regwrite = 1; bus.mem_rd = 5'd4; bus.mem_result = 8'h22;
    bus.wb_regwrite = 1; bus.wb_rd = 5'd4; bus.wb_result = 8'h33;
    #1;
    check("fwd_mem_prio", bus.alu_a, 8'h22);
    check("fwd_rt_none", bus.alu_b, 8'd9);
    bus.mem_regwrite = 0;
    #1;
    check("fwd_wb", bus.alu_a, 8'h33);
    bus.mem_regwrite = 1; bus.mem_rd = 5'd5;
    #1;
    check("fwd_rt_mem_b", bus.alu_b, 8'h22);
    check("fwd_rt_mem_st", bus.ex_store_data, 8'h22);
    check("fwd_rs_wb_kept", bus.alu_a, 8'h33);
    bus.id_valid = 1; bus.id_rs = 5'd0; bus.id_rs_data = 8'd1; bus.id_rt = 5'd0; bus.id_rt_data = 8'd0;
    bus.mem_regwrite = 0;
    tick();
    bus.mem_regwrite = 1; bus.mem_rd = 5'd0; bus.mem_result = 8'h22;
    bus.wb_regwrite = 1; bus.wb_rd = 5'd0; bus.wb_result = 8'h33;
    #1;
    check("fwd_r0_never", bus.alu_a, 8'd1);

    // Load-use detection
    clear_inputs();
    bus.id_valid = 1; bus.id_aluop = 2'b00; bus.id_memread = 1; bus.id_regwrite = 1;
    bus.id_regdst = 0; bus.id_rt = 5'd7; bus.id_rs = 5'd2; bus.id_alusrc = 1; bus.id_imm = 8'd4;
    tick();
    check("ld_ex_dest", bus.ex_dest, 7);
    check("ld_memread", bus.ex_memread, 1);
    check("ld_alu_b_imm", bus.alu_b, 8'd4);
    bus.id_memread = 0; bus.id_rs = 5'd1; bus.id_rt = 5'd7; bus.id_valid = 1;
    #1;
    check("lus_rt", bus.load_use_stall, 1);
    bus.id_valid = 0;
    #1;
    check("lus_invalid", bus.load_use_stall, 0);
    bus.id_valid = 1; bus.id_rs = 5'd7; bus.id_rt = 5'd2;
    #1;
    check("lus_rs", bus.load_use_stall, 1);
    bus.id_rs = 5'd3;
    #1;
    check("lus_nomatch", bus.load_use_stall, 0);
    bus.id_memread = 1; bus.id_rt = 5'd0; bus.id_rs = 5'd2;
    tick();
    bus.id_memread = 0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    #1;
    check("lus_dest0_memread", bus.ex_memread, 1);
    check("lus_dest0", bus.load_use_stall, 0);

    // Stall and flush
    clear_inputs();
    issue_add();
    tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_rs_data = 8'(8'h40 + i); bus.id_rt_data = 8'(8'h50 + i);
      bus.id_funct = 6'b100010; bus.id_rd = 5'd9; bus.id_valid = i[0];
      tick();
      check("stall_alu_op", bus.alu_op, 2);
      check("stall_alu_a", bus.alu_a, 5);
      check("stall_alu_b", bus.alu_b, 3);
      check("stall_dest", bus.ex_dest, 3);
      check("stall_valid", bus.ex_valid, 1);
    end
    bus.flush = 1;
    tick();
    check("flush_valid", bus.ex_valid, 0);
    check("flush_regwrite", bus.ex_regwrite, 0);
    check("flush_alu_op", bus.alu_op, 0);
    check("flush_alu_a", bus.alu_a, 0);
    bus.stall = 0; bus.flush = 0;

    // Op decode sweep
    clear_inputs();
    bus.id_valid = 1;
    for (int i = 0; i < 9; i++) begin
      bus.id_aluop = sw_aluop[i];
      bus.id_funct = sw_funct[i];
      tick();
      check($sformatf("opdec_%0d", i), bus.alu_op, sw_exp[i]);
    end
    bus.id_alusrc = 1; bus.id_imm = 8'hF0; bus.id_rt_data = 8'h0F; bus.id_aluop = 2'b11;
    tick();
    check("imm_alu_b", bus.alu_b, 8'hF0);
    check("imm_store", bus.ex_store_data, 8'h0F);

    // Async reset between edges
    bus.id_alusrc = 0; bus.id_rs = 5'd3; bus.id_rs_data = 8'h11; bus.id_rt_data = 8'h12;
    bus.id_regdst = 1; bus.id_rd = 5'd6; bus.id_memread = 1;
    tick();
    check("pre_rst_valid", bus.ex_valid, 1);
    #2;
    reset = 1;
    #1;
    check("arst_valid", bus.ex_valid, 0);
    check("arst_alu_op", bus.alu_op, 0);
    check("arst_alu_a", bus.alu_a, 0);
    check("arst_alu_b", bus.alu_b, 0);
    check("arst_dest", bus.ex_dest, 0);
    check("arst_lus", bus.load_use_stall, 0);
    tick();
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
